cartridge_flash_loader: RTL and testbench
=========================================

# cartridge_flash_loader

Boot-time loader that copies the game ROM image from the board's parallel NOR flash (asynchronous read mode, 16-bit data) into the cartridge BRAM, one byte per BRAM write. It sits upstream of the cartridge BRAM write port. While `O_BUSY` is high, the top level muxes the BRAM port to this block and holds the CPU in reset. It drives the flash pins that the cartridge simulator currently ties off.

## Interface
Clock and reset: one clock; reset is asynchronous and active-high.

Parameters
- `FLASH_BASE`, default 24'h000000: flash word address of ROM byte 0.
- `NUM_WORDS`, default 16384: number of 16-bit flash words to copy (0..16384). Values above 16384 are a parameter error.
- `WAIT_CYCLES`, default 8: clocks the flash address is held before data is sampled. Must be at least 1.
- `BYTE_ORDER`, default 0: 0 writes `flash_d[7:0]` to the even byte address; 1 writes `flash_d[15:8]` to the even byte address.

Ports
- `I_CLK` in 1: system clock.
- `I_RESET` in 1: asynchronous, active-high reset.
- `I_START` in 1: single-cycle reload request. Honoured only in DONE.
- `flash_d` in 16: flash read data.
- `flash_a` out 24: flash word address (registered).
- `flash_clk` out 1: constant 1.
- `flash_adv_n` out 1: constant 0.
- `flash_we_n` out 1: constant 1.
- `flash_ce_n` out 1: registered, low only in WAIT.
- `flash_oe_n` out 1: registered, low only in WAIT.
- `O_BRAM_WE` out 1: BRAM write strobe.
- `O_BRAM_ADDR` out 15: BRAM byte address.
- `O_BRAM_DIN` out 8: BRAM write data.
- `O_BUSY` out 1: load in progress.
- `O_DONE` out 1: image fully loaded. Sticky until reset or restart.

## Operation
- The state machine has five states: IDLE, WAIT, WR_LO, WR_HI, DONE. Internal registers: a word index (15 bits), a wait counter, and a 16-bit data latch.
- IDLE is the reset state.
  - The first rising edge after `I_RESET` falls moves IDLE to WAIT. On that edge: word index = 0, `flash_a` = `FLASH_BASE`, counter = `WAIT_CYCLES`-1.
  - If `NUM_WORDS` = 0, IDLE goes directly to DONE instead.
- WAIT:
  - `flash_ce_n` and `flash_oe_n` are 0, and `flash_a` is stable.
  - The counter decrements every cycle.
  - On the edge where the counter is 0, `flash_d` is latched and the state moves to WR_LO.
- WR_LO (one cycle):
  - `O_BRAM_WE` = 1 and `O_BRAM_ADDR` = 2*index.
  - `O_BRAM_DIN` = the low or high latched byte, selected by `BYTE_ORDER`.
  - The state moves to WR_HI.
- WR_HI (one cycle):
  - `O_BRAM_WE` = 1, `O_BRAM_ADDR` = 2*index+1, `O_BRAM_DIN` = the other latched byte.
  - If index = `NUM_WORDS`-1, go to DONE.
  - Otherwise increment the index, set `flash_a` = `FLASH_BASE`+index, reload the counter, and go to WAIT.
- DONE:
  - `O_DONE` = 1 and `O_BUSY` = 0.
  - `I_START` = 1 leads to the same transition as leaving IDLE, and `O_DONE` drops on that edge.
- `I_START` is ignored in every state except DONE.
- The BRAM outputs are registered. `O_BRAM_WE` is 0 in every state except WR_LO and WR_HI. `O_BRAM_ADDR` and `O_BRAM_DIN` hold their last value when not writing.
- `flash_a` is computed as `FLASH_BASE` plus the zero-extended index, modulo 2^24.

## Timing
- Reset values: `O_BRAM_WE`=0, `O_BRAM_ADDR`=0, `O_BRAM_DIN`=0, `O_BUSY`=0, `O_DONE`=0, `flash_a`=`FLASH_BASE`, `flash_ce_n`=1, `flash_oe_n`=1. Constant pins are unaffected.
- `O_BUSY` is 1 in WAIT, WR_LO, and WR_HI.
- Each word takes `WAIT_CYCLES`+2 clocks. The full load takes 1 + `NUM_WORDS`*(`WAIT_CYCLES`+2) clocks from the first post-reset edge to `O_DONE`=1.
- Address setup:
  - `flash_a` changes on the same edge that enters WAIT.
  - `flash_d` is sampled `WAIT_CYCLES` edges later.
  - Required access time: `WAIT_CYCLES` * Tclk > tACC(flash).
- Writes to consecutive bytes occur on back-to-back cycles (WR_LO then WR_HI).
- Reset mid-load:
  - All outputs return to their reset values immediately (asynchronous).
  - Any write in flight is aborted and no partial strobe is extended.
  - The load restarts from word 0 after reset release.
- Full image (`NUM_WORDS`=16384): the final write goes to `O_BRAM_ADDR`=15'h7FFF. The index never wraps.

## Test plan
1. Defaults; flash model returns word = {addr[7:0]^8'hA5, addr[7:0]}:
   - BRAM writes at 0,1,2,3 carry 8'h00, 8'hA5, 8'h01, 8'hA4.
   - `O_DONE` rises exactly 1+16384*10 clocks after reset release.
   - The last write address is 15'h7FFF.
2. `WAIT_CYCLES`=3, flash model returns X except in the final WAIT cycle:
   - Latched data is never X.
   - `flash_ce_n` and `flash_oe_n` are low for exactly 3 cycles per word.
   - No BRAM write occurs while `flash_oe_n`=0.
3. `I_RESET` asserted for 1 cycle during word 100's WR_LO:
   - `O_BRAM_WE` goes to 0 asynchronously and `flash_ce_n` goes to 1.
   - After release, the first write goes to address 0.
   - `O_DONE` timing matches scenario 1.
4. `I_START` pulsed at word 5 while busy:
   - The pulse is ignored and the total write count is exactly 2*`NUM_WORDS`.
   - A second `I_START` pulse in DONE drops `O_DONE` on the next edge and repeats the full load from `flash_a`=`FLASH_BASE`.
5. `NUM_WORDS`=0:
   - `O_DONE`=1 one clock after reset release.
   - `O_BRAM_WE` never asserts and `flash_oe_n` stays 1.
6. `BYTE_ORDER`=1 with `FLASH_BASE`=24'h010000 and flash word 16'h1234 at 24'h010000:
   - Address 0 receives 8'h12 and address 1 receives 8'h34.
   - The first `flash_a` value is 24'h010000.

Source files
------------

// File: rtl/cartridge_flash_loader.sv
// cartridge_flash_loader: boot-time copy of a 16-bit NOR flash ROM image into byte-wide cartridge BRAM
module cartridge_flash_loader #(
   parameter logic [23:0] FLASH_BASE = 24'h000000,
   parameter int NUM_WORDS = 16384,
   parameter int WAIT_CYCLES = 8,
   parameter int BYTE_ORDER = 0
) (
   input logic I_CLK,
   input logic I_RESET,
   input logic I_START,
   input logic [15:0] flash_d,
   output logic [23:0] flash_a,
   output logic flash_clk,
   output logic flash_adv_n,
   output logic flash_we_n,
   output logic flash_ce_n,
   output logic flash_oe_n,
   output logic O_BRAM_WE,
   output logic [14:0] O_BRAM_ADDR,
   output logic [7:0] O_BRAM_DIN,
   output logic O_BUSY,
   output logic O_DONE
);
   localparam int CW = WAIT_CYCLES > 1 ? $clog2(WAIT_CYCLES) : 1;
   localparam logic [CW-1:0] RELOAD = CW'(WAIT_CYCLES - 1);
   localparam logic [14:0] LAST = 15'(NUM_WORDS - 1);
   localparam bit EMPTY = NUM_WORDS == 0;
   typedef enum logic [2:0] {IDLE, WAIT, WR_LO, WR_HI, DONE} state_t;
   state_t state, state_n;
   logic [14:0] idx;
   logic [CW-1:0] cnt;
   logic [15:0] latch;
   logic go;
   assign flash_clk = 1'b1;
   assign flash_adv_n = 1'b0;
   assign flash_we_n = 1'b1;
   assign go = state == IDLE || (state == DONE && I_START);
   // next state: start a load on go, hold the address for the access time, then write two bytes
   always_comb begin
      state_n = state;
      case (state)
         IDLE, DONE: if (go) state_n = EMPTY ? DONE : WAIT;
         WAIT: if (cnt == '0) state_n = WR_LO;
         WR_LO: state_n = WR_HI;
         WR_HI: state_n = idx == LAST ? DONE : WAIT;
         default: state_n = IDLE;
      endcase
   end
   // state register
   always_ff @(posedge I_CLK or posedge I_RESET) begin
      if (I_RESET) state <= IDLE;
      else state <= state_n;
   end
   // datapath and registered outputs; outputs follow the state being entered so they align with it
   always_ff @(posedge I_CLK or posedge I_RESET) begin
      if (I_RESET) begin
         idx <= '0;
         cnt <= '0;
         latch <= '0;
         flash_a <= FLASH_BASE;
         flash_ce_n <= 1'b1;
         flash_oe_n <= 1'b1;
         O_BRAM_WE <= 1'b0;
         O_BRAM_ADDR <= '0;
         O_BRAM_DIN <= '0;
         O_BUSY <= 1'b0;
         O_DONE <= 1'b0;
      end else begin
         flash_ce_n <= state_n != WAIT;
         flash_oe_n <= state_n != WAIT;
         O_BRAM_WE <= state_n == WR_LO || state_n == WR_HI;
         O_BUSY <= state_n == WAIT || state_n == WR_LO || state_n == WR_HI;
         O_DONE <= state_n == DONE;
         if (go) begin
            idx <= '0;
            flash_a <= FLASH_BASE;
            cnt <= RELOAD;
         end
         if (state == WAIT) begin
            cnt <= cnt - 1'b1;
            if (cnt == '0) begin
               latch <= flash_d;
               O_BRAM_ADDR <= {idx[13:0], 1'b0};
               O_BRAM_DIN <= BYTE_ORDER != 0 ? flash_d[15:8] : flash_d[7:0];
            end
         end
         if (state == WR_LO) begin
            O_BRAM_ADDR <= {idx[13:0], 1'b1};
            O_BRAM_DIN <= BYTE_ORDER != 0 ? latch[7:0] : latch[15:8];
         end
         if (state == WR_HI && idx != LAST) begin
            idx <= idx + 15'd1;
            flash_a <= FLASH_BASE + {9'd0, idx + 15'd1};
            cnt <= RELOAD;
         end
      end
   end
endmodule

// File: tb/tb_cartridge_flash_loader.sv
// tb_cartridge_flash_loader: scoreboard bench for the flash-to-BRAM loader
module tb_cartridge_flash_loader;
   localparam logic [23:0] BASE = 24'hFFFFF8;
   localparam int NW = 120;
   localparam int W = 3;
   localparam int EXP_CYC = 1 + NW * (W + 2);
   localparam int F_NW = 16384;
   localparam int F_CYC = 1 + F_NW * 3;
   logic clk = 1'b0, rst = 1'b1, rst_f = 1'b1, start = 1'b0;
   logic [15:0] fd;
   logic [23:0] fa;
   logic fclk, fadv_n, fwe_n, fce_n, foe_n, we, busy, done;
   logic [14:0] addr;
   logic [7:0] din;
   logic [15:0] fd_f;
   logic [23:0] fa_f;
   logic f_unused0, f_unused1, f_unused2, f_ce_n, f_oe_n, f_we, f_busy, f_done;
   logic [14:0] f_addr;
   logic [7:0] f_din;
   logic [23:0] z_fa;
   logic z_unused0, z_unused1, z_unused2, z_ce_n, z_oe_n, z_we, z_busy, z_done;
   logic [14:0] z_addr;
   logic [7:0] z_din;
   int total = 0, bad = 0;
   int low_cyc = 0, exp_word = 0, wr_cnt = 0;
   logic [14:0] first_addr = '0, last_addr = '0;
   logic [22:0] q[$];
   logic f_fin = 1'b0, z_bad = 1'b0;
   always #5 clk = ~clk;
   function automatic logic [15:0] fw(input logic [23:0] a);
      return {a[7:0] ^ 8'hA5, a[7:0]};
   endfunction
   // flash model drives valid data only in the last cycle of the access window
   assign fd = (!foe_n && low_cyc == W) ? fw(fa) : 16'hDEAD;
   assign fd_f = fw(fa_f);
   cartridge_flash_loader #(.FLASH_BASE(BASE), .NUM_WORDS(NW), .WAIT_CYCLES(W), .BYTE_ORDER(1)) dut (
      .I_CLK(clk), .I_RESET(rst), .I_START(start), .flash_d(fd), .flash_a(fa), .flash_clk(fclk),
      .flash_adv_n(fadv_n), .flash_we_n(fwe_n), .flash_ce_n(fce_n), .flash_oe_n(foe_n), .O_BRAM_WE(we),
      .O_BRAM_ADDR(addr), .O_BRAM_DIN(din), .O_BUSY(busy), .O_DONE(done));
   cartridge_flash_loader #(.NUM_WORDS(F_NW), .WAIT_CYCLES(1)) dut_f (
      .I_CLK(clk), .I_RESET(rst_f), .I_START(1'b0), .flash_d(fd_f), .flash_a(fa_f), .flash_clk(f_unused0),
      .flash_adv_n(f_unused1), .flash_we_n(f_unused2), .flash_ce_n(f_ce_n), .flash_oe_n(f_oe_n), .O_BRAM_WE(f_we),
      .O_BRAM_ADDR(f_addr), .O_BRAM_DIN(f_din), .O_BUSY(f_busy), .O_DONE(f_done));
   cartridge_flash_loader #(.NUM_WORDS(0)) dut_z (
      .I_CLK(clk), .I_RESET(rst_f), .I_START(1'b0), .flash_d(16'h0000), .flash_a(z_fa), .flash_clk(z_unused0),
      .flash_adv_n(z_unused1), .flash_we_n(z_unused2), .flash_ce_n(z_ce_n), .flash_oe_n(z_oe_n), .O_BRAM_WE(z_we),
      .O_BRAM_ADDR(z_addr), .O_BRAM_DIN(z_din), .O_BUSY(z_busy), .O_DONE(z_done));
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   // main-DUT monitor: push expected bytes when a word is fetched, pop and compare on each write
   always @(negedge clk) begin
      logic [23:0] a;
      logic [15:0] w;
      logic [22:0] e;
      if (!rst) begin
         if (!foe_n) begin
            low_cyc++;
            if (low_cyc == W) begin
               a = BASE + 24'(exp_word);
               w = fw(a);
               chk("flash_a", fa, a);
               chk("ce_eq_oe", fce_n, foe_n);
               q.push_back({15'(2 * exp_word), w[15:8]});
               q.push_back({15'(2 * exp_word + 1), w[7:0]});
               exp_word++;
            end
         end else begin
            if (low_cyc != 0) chk("oe_low_len", low_cyc, W);
            low_cyc = 0;
         end
         if (we) begin
            chk("wr_oe_high", foe_n, 1);
            chk("q_nonempty", q.size() != 0, 1);
            if (q.size() != 0) begin
               e = q.pop_front();
               chk("wr_addr", addr, e[22:8]);
               chk("wr_data", din, e[7:0]);
            end
            if (wr_cnt == 0) first_addr = addr;
            last_addr = addr;
            wr_cnt++;
         end
      end
   end
   // zero-word DUT must never touch the flash or the BRAM
   always @(negedge clk) if (!rst_f && (z_we || !z_oe_n)) z_bad = 1'b1;
   task automatic wait_done(input string tag, input int start_at);
      int n;
      for (n = 1; n <= 3000; n++) begin
         @(negedge clk);
         start = (n == start_at);
         if (n == 1) begin
            chk({tag, "_done_low"}, done, 0);
            chk({tag, "_busy"}, busy, 1);
         end
         if (done) break;
      end
      chk({tag, "_cycles"}, n, EXP_CYC);
      chk({tag, "_wr_cnt"}, wr_cnt, 2 * NW);
      chk({tag, "_q_empty"}, q.size(), 0);
      chk({tag, "_first"}, first_addr, 0);
      chk({tag, "_last"}, last_addr, 2 * NW - 1);
   endtask
   // full-image DUT: timing, first bytes and final address
   initial begin
      int n, wrs;
      logic [14:0] last;
      logic [15:0] w;
      wrs = 0;
      last = '0;
      @(negedge clk);
      @(negedge clk);
      #2 rst_f = 1'b0;
      for (n = 1; n <= 60000; n++) begin
         @(negedge clk);
         if (n == 1) chk("z_done", z_done, 1);
         if (f_we) begin
            if (wrs < 4) begin
               w = fw(24'(wrs / 2));
               chk("f_first_bytes", f_din, wrs[0] ? w[15:8] : w[7:0]);
            end
            last = f_addr;
            wrs++;
         end
         if (f_done) break;
      end
      chk("f_cycles", n, F_CYC);
      chk("f_wr_cnt", wrs, 2 * F_NW);
      chk("f_last", last, 15'h7FFF);
      chk("z_quiet", z_bad, 0);
      chk("z_busy", z_busy, 0);
      f_fin = 1'b1;
   end
   initial begin
      int i;
      @(negedge clk);
      chk("rst_we", we, 0);
      chk("rst_addr", addr, 0);
      chk("rst_din", din, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_fa", fa, BASE);
      chk("rst_ce", fce_n, 1);
      chk("rst_oe", foe_n, 1);
      chk("const_pins", {fclk, fadv_n, fwe_n}, 3'b101);
      @(negedge clk);
      #2 rst = 1'b0;
      wait_done("run1", 0);
      @(negedge clk);
      exp_word = 0;
      wr_cnt = 0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("restart_done_low", done, 0);
      chk("restart_busy", busy, 1);
      chk("restart_fa", fa, BASE);
      for (i = 0; i < 2000 && !(we && addr == 15'd200); i++) @(negedge clk);
      chk("reach_word100", we && addr == 15'd200, 1);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_we", we, 0);
      chk("mid_rst_ce", fce_n, 1);
      chk("mid_rst_oe", foe_n, 1);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_fa", fa, BASE);
      q.delete();
      exp_word = 0;
      wr_cnt = 0;
      low_cyc = 0;
      @(negedge clk);
      #2 rst = 1'b0;
      wait_done("run_after_rst", 28);
      for (i = 0; i < 60000 && !f_fin; i++) @(negedge clk);
      chk("full_finished", f_fin, 1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
